// File: rtl/fm_discriminator_if.sv
// FM discriminator sample/config/result bundle.
// Latency: none (wires only).
// Backpressure: none; samples are qualified by i_ce, results by o_valid/o_timeout pulses.
interface fm_discriminator_if #(
  parameter int sine_lookup_width = 16,
  parameter int period_width      = 16
);
  logic                          i_ce;
  logic                          i_update;
  logic signed [sine_lookup_width:0] i_sample;
  logic [period_width-1:0]       i_center_period;
  logic [sine_lookup_width-1:0]  i_hysteresis;
  logic [period_width-1:0]       o_period;
  logic signed [period_width:0]  o_deviation;
  logic                          o_valid;
  logic                          o_locked;
  logic                          o_timeout;

  // Sample source / result consumer side.
  modport master (
    output i_ce, i_update, i_sample, i_center_period, i_hysteresis,
    input  o_period, o_deviation, o_valid, o_locked, o_timeout
  );

  // Discriminator side.
  modport slave (
    input  i_ce, i_update, i_sample, i_center_period, i_hysteresis,
    output o_period, o_deviation, o_valid, o_locked, o_timeout
  );
endinterface

// File: rtl/fm_discriminator.sv
// FM discriminator: measures carrier period between Schmitt-triggered rising crossings.
// Latency: o_valid/o_timeout one clock after the i_ce cycle carrying the triggering sample.
// Backpressure: none; every i_ce sample is consumed, results are single-cycle pulses.
module fm_discriminator #(
  parameter int sine_lookup_width = 16,
  parameter int period_width      = 16
) (
  input logic               i_clk,
  input logic               i_reset,
  fm_discriminator_if.slave bus
);
  localparam int SW = sine_lookup_width;
  localparam int PW = period_width;

  localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};
  localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};

  localparam logic [0:0] ACQUIRE = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  logic [0:0]    state;
  logic          pol_pos;
  logic [PW-1:0] count;
  logic [PW-1:0] cfg_center;
  logic [SW-1:0] cfg_hyst;

  // Two extra bits so both +hyst and -hyst fit alongside the signed sample.
  logic signed [SW+1:0] sample_ext;
  logic signed [SW+1:0] hyst_pos;
  logic signed [SW+1:0] hyst_neg;
  logic                 above;
  logic                 below;
  logic                 rise;
  logic [PW-1:0]        meas_period;
  logic signed [PW:0]   meas_dev;

  assign sample_ext = {bus.i_sample[SW], bus.i_sample};
  assign hyst_pos   = $signed({2'b00, cfg_hyst});
  assign hyst_neg   = -hyst_pos;
  assign above      = (sample_ext >= hyst_pos);
  assign below      = (sample_ext < hyst_neg);
  assign rise       = bus.i_ce && !pol_pos && above;

  // A period that would overflow the counter saturates at the counter maximum.
  assign meas_period = (count == CNT_MAX) ? CNT_MAX : count + CNT_ONE;
  // One extra bit makes the unsigned difference exact for any operand values.
  assign meas_dev    = $signed({1'b0, meas_period}) - $signed({1'b0, cfg_center});

  // Config registers load whenever i_update is set, regardless of i_ce.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cfg_center <= '0;
      cfg_hyst   <= '0;
    end else if (bus.i_update) begin
      cfg_center <= bus.i_center_period;
      cfg_hyst   <= bus.i_hysteresis;
    end
  end

  // Schmitt polarity: flips only when the sample clears the hysteresis band.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pol_pos <= 1'b1;
    end else if (bus.i_ce) begin
      if (below) begin
        pol_pos <= 1'b0;
      end else if (above) begin
        pol_pos <= 1'b1;
      end
    end
  end

  // Acquire/measure state machine with registered result and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= ACQUIRE;
      count           <= '0;
      bus.o_period    <= '0;
      bus.o_deviation <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_locked    <= 1'b0;
      bus.o_timeout   <= 1'b0;
    end else begin
      bus.o_valid   <= 1'b0;
      bus.o_timeout <= 1'b0;
      if (bus.i_ce) begin
        case (state)
          ACQUIRE: begin
            count <= '0;
            if (rise) begin
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              // An edge landing on a full counter still counts; it just saturates.
              bus.o_period    <= meas_period;
              bus.o_deviation <= meas_dev;
              bus.o_valid     <= 1'b1;
              bus.o_locked    <= 1'b1;
              count           <= '0;
            end else if (count == CNT_MAX) begin
              bus.o_timeout <= 1'b1;
              bus.o_locked  <= 1'b0;
              count         <= '0;
              state         <= ACQUIRE;
            end else begin
              count <= count + CNT_ONE;
            end
          end
          default: begin
            state <= ACQUIRE;
            count <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/fm_discriminator.md
FM_DISCRIMINATOR -- requirements
Module: fm_discriminator

Interface
REQ-001 SHALL have parameter sine_lookup_width, default 16, meaning sample magnitude width (sample is sine_lookup_width+1 bits signed).
REQ-002 SHALL have parameter period_width, default 16, meaning period counter width in samples.
REQ-003 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_ce  input  1  sample enable; one input sample per cycle with i_ce=1.
REQ-006 SHALL have port i_update  input  1  loads config registers from i_center_period/i_hysteresis.
REQ-007 SHALL have port i_sample  input  sine_lookup_width+1  signed input sample (FM waveform from the team's DDS/FM generator).
REQ-008 SHALL have port i_center_period  input  period_width  unsigned expected carrier period, in samples.
REQ-009 SHALL have port i_hysteresis  input  sine_lookup_width  unsigned Schmitt threshold magnitude.
REQ-010 SHALL have port o_period  output  period_width  unsigned last measured period, in samples.
REQ-011 SHALL have port o_deviation  output  period_width+1  signed o_period minus center period.
REQ-012 SHALL have port o_valid  output  1  one-cycle pulse, new o_period/o_deviation.
REQ-013 SHALL have port o_locked  output  1  level, at least one period measured since last acquire.
REQ-014 SHALL have port o_timeout  output  1  one-cycle pulse, carrier lost.

Function
REQ-015 SHALL hold cfg_center and cfg_hyst registers, loaded on any cycle with i_update=1, independent of i_ce.
REQ-016 SHALL keep a Schmitt polarity bit: set NEG when i_sample < -cfg_hyst; set POS when i_sample >= +cfg_hyst; otherwise hold. Updated only on i_ce cycles.
REQ-017 SHALL flag a rising event on an i_ce cycle where polarity is NEG and i_sample >= +cfg_hyst.
REQ-018 SHALL implement states ACQUIRE and MEASURE; reset state ACQUIRE.
REQ-019 ACQUIRE: counter held at 0; rising event -> MEASURE, counter cleared to 0, no o_valid.
REQ-020 MEASURE, i_ce with rising event: o_period <= min(counter+1, 2^period_width-1), o_deviation <= o_period value minus cfg_center (sign-extended, full width, no overflow), o_valid pulses, o_locked <= 1, counter <= 0.
REQ-021 MEASURE, i_ce without event, counter < max: counter increments by 1.
REQ-022 MEASURE, i_ce without event, counter == 2^period_width-1: o_timeout pulses, o_locked <= 0, counter <= 0, state -> ACQUIRE; o_period/o_deviation hold.
REQ-023 Rising event and counter==max simultaneously: event wins, period saturates to max, no timeout.
REQ-024 Output latency: o_valid/o_timeout asserted on the clock edge following the i_ce cycle carrying the triggering sample (registered, one cycle).
REQ-025 o_valid and o_timeout SHALL be low on every cycle not following a triggering i_ce cycle; never high together.
REQ-026 i_ce=0 cycles SHALL change no state except config registers (REQ-015).
REQ-027 i_update coinciding with an event: the event uses the pre-update cfg values; new values apply from next i_ce cycle.
REQ-028 cfg_hyst=0: NEG when i_sample<0, POS when i_sample>=0.

Reset
REQ-029 While i_reset=1 at a clock edge: state ACQUIRE, polarity POS, counter 0, cfg_center 0, cfg_hyst 0, o_period 0, o_deviation 0, o_valid 0, o_locked 0, o_timeout 0.
REQ-030 Reset SHALL take priority over i_ce and i_update; reset mid-measurement discards the partial period.

Verification
REQ-031 i_update with center=8, hyst=100; square wave +-1000 every sample, rising every 8 samples -> first edge no o_valid; each later edge o_valid, o_period=8, o_deviation=0, o_locked=1.
REQ-032 Same wave, center=10 -> o_period=8, o_deviation=-2; center=5 -> o_deviation=+3.
REQ-033 period_width=6, lock, then hold i_sample=0 with hyst=100 -> o_timeout pulses exactly 64 i_ce samples after last event, o_locked=0, next edge gives no o_valid.
REQ-034 Noise +-50 around 0 with hyst=100 superimposed on the locked wave -> no extra events, o_period stays 8.
REQ-035 Same wave with i_ce high every other clock -> o_period=8, o_valid rate halves in clocks.
REQ-036 Assert i_reset for one cycle mid-period -> all outputs 0 next edge; first following edge no o_valid; second edge o_valid with correct period.
